// File: rtl/man_pkg.sv
`default_nettype none
// ============================================================================
// Module      : man_pkg
// Description : Shared definitions for the Manchester encoder/decoder pair:
//               FSM state encoding, per-bit half-level patterns and the line
//               idle level. Half-level pairs are {first half, second half}.
// Revision    : 1.0 - initial release
// ============================================================================
package man_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } man_state_t;

    // Bit 1 is low-then-high, bit 0 is high-then-low.
    localparam logic [1:0] c_half_one  = 2'b01;
    localparam logic [1:0] c_half_zero = 2'b10;
    localparam logic       c_line_idle = 1'b0;

    function automatic logic first_half(input logic b);
        logic [1:0] lv;
        lv = b ? c_half_one : c_half_zero;
        return lv[1];
    endfunction

    function automatic logic second_half(input logic b);
        logic [1:0] lv;
        lv = b ? c_half_one : c_half_zero;
        return lv[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/man_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : man_bit_timer
// Description : Half-bit timer. Counts 0..HALF_BIT-1 while run is high and
//               raises tick during the terminal count cycle. start forces the
//               count back to 0 at the next edge.
// Ports       : clk, rst (async, active-high), start, run -> tick
// Revision    : 1.0 - initial release
// ============================================================================
module man_bit_timer
    import man_pkg::*;
#(
    parameter int HALF_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic tick
);

    localparam int CW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [CW-1:0] c_last = CW'(HALF_BIT - 1);

    logic [CW-1:0] r_cnt;

    // Tick is not masked by start: the encoder uses the tick of the final
    // half-bit to decide whether a chained frame may be accepted.
    assign tick = run && (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start || tick) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/man_encoder.sv
`default_nettype none
// ============================================================================
// Module      : man_encoder
// Description : Manchester line encoder. Accepts an NBITS word over
//               valid/ready and sends it MSB first, each half-bit lasting
//               HALF_BIT clocks. Optional preamble of PRE_BITS alternating
//               bits (1,0,1,0...) is built when MAN_PREAMBLE_EN is defined.
// Ports       : clk, rst (async, active-high)
//               din[NBITS-1:0], valid -> ready (combinational)
//               out (registered line), busy, done (one-cycle pulse)
// Config      : `define MAN_PREAMBLE_EN to build the preamble state.
// Revision    : 1.0 - initial release
// ============================================================================
module man_encoder
    import man_pkg::*;
#(
    parameter int HALF_BIT = 4,
    parameter int NBITS    = 8,
    parameter int PRE_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] din,
    input  logic             valid,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int MAXB = (NBITS > PRE_BITS) ? NBITS : PRE_BITS;
    localparam int BCW  = $clog2(MAXB + 1);
    localparam logic [BCW-1:0] c_data_last = BCW'(NBITS - 1);
`ifdef MAN_PREAMBLE_EN
    localparam logic [BCW-1:0] c_pre_last  = BCW'(PRE_BITS - 1);
`endif

    man_state_t       r_state;
    man_state_t       w_state_nxt;
    logic [NBITS-1:0] r_shift;
    logic [NBITS-1:0] w_shift_nxt;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_nxt;
    logic             r_half;       // 0 = first half of bit, 1 = second half
    logic             w_half_nxt;
    logic             w_out_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_tick;
    logic             w_run;
    logic             w_accept;
    logic             w_last_tick;
    logic             w_cur_bit;

    man_bit_timer #(
        .HALF_BIT (HALF_BIT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .run   (w_run),
        .tick  (w_tick)
    );

    assign w_run       = (r_state != ST_IDLE);
    // Final clock of a frame: terminal count of the second half of the LSB.
    assign w_last_tick = (r_state == ST_DATA) && r_half
                         && (r_bit_cnt == c_data_last) && w_tick;
    assign ready       = (r_state == ST_IDLE) || w_last_tick;
    assign w_accept    = valid && ready;

`ifdef MAN_PREAMBLE_EN
    // Preamble bit k is 1 for even k, 0 for odd k.
    assign w_cur_bit = (r_state == ST_PRE) ? ~r_bit_cnt[0] : r_shift[NBITS-1];
`else
    assign w_cur_bit = r_shift[NBITS-1];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_half_nxt  = r_half;
        w_out_nxt   = out;
        w_done_nxt  = 1'b0;

        if (w_accept) begin
            // New frame; when chaining, the finished frame still reports done.
            w_shift_nxt = din;
            w_bit_nxt   = '0;
            w_half_nxt  = 1'b0;
            w_done_nxt  = w_last_tick;
`ifdef MAN_PREAMBLE_EN
            w_state_nxt = ST_PRE;
            w_out_nxt   = first_half(1'b1);
`else
            w_state_nxt = ST_DATA;
            w_out_nxt   = first_half(din[NBITS-1]);
`endif
        end else if (w_tick) begin
            if (!r_half) begin
                w_half_nxt = 1'b1;
                w_out_nxt  = second_half(w_cur_bit);
            end else begin
                w_half_nxt = 1'b0;
                case (r_state)
`ifdef MAN_PREAMBLE_EN
                    ST_PRE: begin
                        if (r_bit_cnt == c_pre_last) begin
                            w_state_nxt = ST_DATA;
                            w_bit_nxt   = '0;
                            w_out_nxt   = first_half(r_shift[NBITS-1]);
                        end else begin
                            w_bit_nxt   = r_bit_cnt + BCW'(1);
                            // Next preamble bit is the opposite of the current one.
                            w_out_nxt   = first_half(r_bit_cnt[0]);
                        end
                    end
`endif
                    ST_DATA: begin
                        if (r_bit_cnt == c_data_last) begin
                            w_state_nxt = ST_IDLE;
                            w_bit_nxt   = '0;
                            w_out_nxt   = c_line_idle;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_shift_nxt = {r_shift[NBITS-2:0], 1'b0};
                            w_bit_nxt   = r_bit_cnt + BCW'(1);
                            w_out_nxt   = first_half(r_shift[NBITS-2]);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_half    <= 1'b0;
            out       <= c_line_idle;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_half    <= w_half_nxt;
            out       <= w_out_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/man_encoder.md
# man_encoder

Manchester line encoder that sits directly upstream of the Manchester decoder and drives its serial `in` line. It accepts a parallel word over a valid/ready handshake and emits it MSB-first as a Manchester waveform. Each half-bit lasts a fixed number of `clk` cycles, so the decoder's edge detector and one-shot see clean mid-bit transitions. The block is also the stimulus source for decoder loopback tests.

## Interface
- `HALF_BIT`, 4: clk cycles per half-bit; legal range ≥ 2.
- `NBITS`, 8: data bits per frame.
- `PRE_BITS`, 8: preamble bit count; used only when `MAN_PREAMBLE_EN` is defined.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din` input NBITS: word to send; sampled only on acceptance.
- `valid` input 1: `din` is offered.
- `ready` output 1: encoder can accept this cycle.
- `out` output 1: registered Manchester line; idle level 0.
- `busy` output 1: a frame is on the line.
- `done` output 1: one-cycle pulse after the last half-bit of a frame.

## Operation
- Encoding: bit 1 is sent as low then high (rising mid-bit edge). Bit 0 is sent as high then low (falling mid-bit edge). Bit order is MSB first.
- FSM states:
  - IDLE: `ready`=1, `busy`=0, `out`=0.
  - PRE: only when the macro is defined.
  - DATA.
- Acceptance: `valid && ready` at a rising edge.
  - `din` is latched into a shift register.
  - The FSM goes to PRE, or to DATA when the macro is undefined.
  - `out` takes the first half-level of the first bit at that same edge.
- Half-bit timer: counts 0..HALF_BIT-1 and ticks on the terminal count. On each tick:
  - `out` switches to the second half of the current bit, or
  - `out` switches to the first half of the next bit, shifting the register on the bit boundary.
- Bit counter width: clog2 of max(NBITS, PRE_BITS)+1.
- End of frame: the tick that ends the last half-bit of bit 0 (LSB).
  - If `valid` is not asserted then: FSM → IDLE, `out`←0, `done`=1 for one cycle.
  - If `valid` is asserted then: chaining applies (see below).
- `ready` is 1 in IDLE and in the final clock of a frame (last cycle of the last half-bit).
- Chaining: acceptance in the final clock starts the next frame at the following edge with no idle gap. `done` still pulses for the finished frame.
- `valid` asserted in any other cycle is ignored. Changes on `din` during a frame have no effect.
- Reset, including mid-frame: immediately forces IDLE, `out`=0, `busy`=0, `done`=0, `ready`=1. The partial frame is discarded and no `done` is issued.
- Equal consecutive bits produce a boundary transition. Opposite consecutive bits produce none.

## Timing
- Reset values: `out`=0, `ready`=1, `busy`=0, `done`=0, counters 0, FSM IDLE.
- Acceptance at edge E0: the first half-level appears on `out` after E0.
- Frame length without preamble: 2·NBITS·HALF_BIT cycles (64 at defaults). `busy`=1 for exactly this span.
- Frame length with preamble: add 2·PRE_BITS·HALF_BIT cycles.
- `done` is high in the cycle after the last half-bit ends, i.e. at E0+64 at defaults.
- Back-to-back frames are spaced exactly one frame length apart.
- `ready` is combinational from state and counters. `out`, `busy` and `done` are registered.

## Configuration
- `MAN_PREAMBLE_EN` defined:
  - PRE state is built.
  - PRE_BITS alternating bits 1,0,1,0… are sent before the data, giving the decoder a sync pattern.
  - `busy` covers the preamble. `done` fires only after the data.
- `MAN_PREAMBLE_EN` undefined: PRE state and its logic are absent, and acceptance goes straight to DATA.

## Structure
- Shared package `man_pkg` holds:
  - the FSM state encoding (IDLE, PRE, DATA);
  - the half-level constants for 1 = {0,1} and 0 = {1,0};
  - the line idle level 0.
- The decoder package side reuses the same encoding constants.
- One sub-module, `man_bit_timer`:
  - inputs: `clk`, `rst`, `start`, `run`;
  - behaviour: parameterised HALF_BIT counter;
  - output: one-cycle `tick` at the half-bit end;
  - `start` restarts the count at 0.

## Test plan
- Defaults, no macro, `din`=8'hA5: `out` is 0000 1111, 1111 0000, 0000 1111, 1111 0000, 1111 0000, 0000 1111, 1111 0000, 0000 1111 (4 clk each, 64 cycles). `done` is high at cycle 64, then `out` returns to 0.
- Back-to-back: 8'hFF then 8'h00 with `valid` held.
  - `ready` is high only at cycle 0 and cycle 63.
  - The second frame starts at cycle 64 with no gap.
  - `done` pulses at cycles 64 and 128.
- Ignored inputs:
  - `valid` pulsed at cycle 10 with `din`=8'h00 during an 8'hC3 frame: no effect, output is 8'hC3.
  - `din` toggled mid-frame: no effect.
- Reset mid-frame: `rst` pulsed at cycle 20 of a frame.
  - `out`, `busy`, `done` go to 0 and `ready` to 1 without waiting for a clock edge.
  - No `done` for that frame.
  - The next frame encodes correctly.
- `MAN_PREAMBLE_EN`, PRE_BITS=8, `din`=8'h3C:
  - 64 cycles of the 1010… Manchester pattern, then the data.
  - `done` at cycle 128.
  - `busy` spans 128 cycles.
- Loopback into the Manchester decoder at HALF_BIT=4, `din`=8'h3C: the decoder emits 8 `strobe` pulses with `data` sequence 0,0,1,1,1,1,0,0.
